// File: rtl/prng_arb_pkg.sv
// Shared definitions for the PRNG arbiter: controller state encoding, seed width
// and the counter-width helper.
package prng_arb_pkg;

    localparam int SEED_W = 80;

    localparam logic [2:0] ST_UNSEEDED  = 3'd0;
    localparam logic [2:0] ST_KICK      = 3'd1;
    localparam logic [2:0] ST_WAIT      = 3'd2;
    localparam logic [2:0] ST_SERVE     = 3'd3;
    localparam logic [2:0] ST_NEED_SEED = 3'd4;

    typedef enum logic [2:0] {
        UNSEEDED  = ST_UNSEEDED,
        KICK      = ST_KICK,
        WAIT      = ST_WAIT,
        SERVE     = ST_SERVE,
        NEED_SEED = ST_NEED_SEED
    } arb_state_t;

    // Width needed to hold the value 'period'; never narrower than one bit.
    function automatic int cnt_width(input int period);
        return (period < 1) ? 1 : $clog2(period + 1);
    endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// Bundle of the seed channel, PRNG wrapper handshake and requester signals
// around prng_arbiter; master is the arbiter side, slave the surroundings.
interface prng_arbiter_if #(
    parameter int RND   = 1,
    parameter int N_REQ = 4
);
    import prng_arb_pkg::*;

    logic              seed_valid;
    logic              seed_ready;
    logic [SEED_W-1:0] seed;
    logic              prng_start_reseed;
    logic [SEED_W-1:0] prng_seed;
    logic              prng_busy;
    logic              prng_out_valid;
    logic              prng_out_ready;
    logic [RND-1:0]    prng_out_rnd;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  grant;
    logic [RND-1:0]    rnd_data;
    logic              reseeding;

    modport master (
        input  seed_valid, seed, prng_busy, prng_out_valid, prng_out_rnd, req,
        output seed_ready, prng_start_reseed, prng_seed, prng_out_ready,
               grant, rnd_data, reseeding
    );

    modport slave (
        output seed_valid, seed, prng_busy, prng_out_valid, prng_out_rnd, req,
        input  seed_ready, prng_start_reseed, prng_seed, prng_out_ready,
               grant, rnd_data, reseeding
    );

endinterface

// File: rtl/prng_rr_arbiter.sv
// Combinational rotating-priority picker: grants the first eligible index at or
// after ptr (wrapping) and reports the pointer that follows the winner.
module prng_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] next_ptr
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (enable && !found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((int'(idx) + 1) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/prng_arbiter.sv
// Seeds/reseeds one Trivium PRNG wrapper and shares its output among N_REQ consumers.
// Define PRNG_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module prng_arbiter
    import prng_arb_pkg::*;
#(
    parameter int RND           = 1,
    parameter int N_REQ         = 4,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    prng_arbiter_if.master bus
);

    localparam int CNT_W = cnt_width(RESEED_PERIOD);
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(RESEED_PERIOD);

    arb_state_t        state_q, state_d;
    logic              kick_q;
    logic [SEED_W-1:0] seed_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  grant;
    logic [PTR_W-1:0]  ptr_q;
    logic              serving;
    logic              xfer;
    logic              last_xfer;
    logic              seed_ready;
    logic              seed_take;

    assign serving   = (state_q == SERVE);
    assign eligible  = bus.req & {N_REQ{bus.prng_out_valid}};
    assign xfer      = |grant;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_xfer = (RESEED_PERIOD != 0) && xfer && (cnt_inc == PERIOD_C);
    assign seed_take = seed_ready && bus.seed_valid;

`ifdef PRNG_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_next;

    prng_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .enable   (serving),
        .grant    (grant),
        .next_ptr (ptr_next)
    );

    // The pointer only moves on an actual transfer, so valid gaps keep the turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= ptr_next;
        end
    end
`else
    logic [PTR_W-1:0] unused_ptr_next;

    // A search that always starts at index 0 is plain fixed priority.
    assign ptr_q = '0;

    prng_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .enable   (serving),
        .grant    (grant),
        .next_ptr (unused_ptr_next)
    );
`endif

    always_comb begin
        state_d    = state_q;
        seed_ready = 1'b0;
        case (state_q)
            UNSEEDED, NEED_SEED: begin
                seed_ready = 1'b1;
                if (bus.seed_valid) state_d = KICK;
            end
            KICK:    state_d = WAIT;
            // The pulse cycle itself never exits: the wrapper has not reacted yet.
            WAIT:    if (!kick_q && !bus.prng_busy && bus.prng_out_valid) state_d = SERVE;
            SERVE:   if (last_xfer) state_d = NEED_SEED;
            default: state_d = UNSEEDED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNSEEDED;
            kick_q  <= 1'b0;
            seed_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kick_q  <= (state_q == KICK);
            if (seed_take) seed_q <= bus.seed;
            if (state_d == KICK) begin
                cnt_q <= '0;
            end else if (xfer && (RESEED_PERIOD != 0)) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign bus.seed_ready        = seed_ready;
    assign bus.prng_start_reseed = kick_q;
    assign bus.prng_seed         = seed_q;
    assign bus.prng_out_ready    = xfer;
    assign bus.grant             = grant;
    assign bus.rnd_data          = bus.prng_out_rnd;
    assign bus.reseeding         = !serving;

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: stubbed PRNG wrapper, table-driven cold start and
// arbitration, hand sequences for reseed/gap/reset, random traffic vs a model.
module tb_prng_arbiter;
    import prng_arb_pkg::*;

    localparam int N      = 4;
    localparam int IW     = $clog2(N);
    localparam int RND    = 8;
    localparam int PERIOD = 8;
`ifdef PRNG_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [SEED_W-1:0] COLD_SEED = 80'h0123456789ABCDEF0123;
    localparam logic [SEED_W-1:0] HIGH_SEED = 80'hFFFF_FFFF_FFFF_FFFF_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prng_arbiter_if #(.RND(RND), .N_REQ(N)) bus ();

    prng_arbiter #(.RND(RND), .N_REQ(N), .RESEED_PERIOD(PERIOD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [N-1:0] grant;
        logic         seed_ready;
        logic         start;
        logic         reseeding;
        logic         out_ready;
    } smp_t;

    typedef struct {
        logic sv; logic bz; logic vl;
        logic e_sr; logic e_st; logic e_rs;
    } cold_t;

    typedef struct {
        logic [N-1:0] rq;
        logic [N-1:0] e_g;
        logic         e_sr;
    } arb_t;

    cold_t cold_tab[8];
    arb_t  arb_tab[9];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the arbiter has promised so far.
    bit                m_want_seed;
    int                m_age;       // cycles since seed acceptance, -1 when no seed in flight
    bit                m_serving;
    int                m_xfers;
    int                m_next;
    logic [SEED_W-1:0] m_seed;

    // PRNG wrapper stub
    bit stub_seeded;
    int stub_busy_left;
    int busy_len = 3;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_want_seed    = 1'b1;
        m_age          = -1;
        m_serving      = 1'b0;
        m_xfers        = 0;
        m_next         = 0;
        m_seed         = '0;
        stub_seeded    = 1'b0;
        stub_busy_left = 0;
    endtask

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] rq, input logic vl);
        logic [N-1:0] g;
        logic [IW-1:0] ix;
        int first;
        g = '0;
        if (m_serving && vl) begin
            first = RR ? m_next : 0;
            for (int k = 0; k < N; k++) begin
                ix = IW'((first + k) % N);
                if (g == '0 && rq[ix]) g[ix] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_cycle();
        logic [N-1:0] eg;
        int gi;
        eg = model_grant(bus.req, bus.prng_out_valid);
        chk("grant",        128'(bus.grant),             128'(eg));
        chk("out_ready",    128'(bus.prng_out_ready),    128'(|eg));
        chk("seed_ready",   128'(bus.seed_ready),        128'(m_want_seed));
        chk("start_reseed", 128'(bus.prng_start_reseed), 128'(m_age == 2));
        chk("reseeding",    128'(bus.reseeding),         128'(!m_serving));
        chk("rnd_data",     128'(bus.rnd_data),          128'(bus.prng_out_rnd));
        chk("prng_seed",    128'(bus.prng_seed),         128'(m_seed));
        gi = -1;
        for (int i = 0; i < N; i++) if (eg[IW'(i)]) gi = i;
        if (m_want_seed) begin
            if (bus.seed_valid) begin
                m_seed      = bus.seed;
                m_want_seed = 1'b0;
                m_age       = 1;
                m_xfers     = 0;
            end
        end else if (m_serving) begin
            if (gi >= 0) begin
                m_next = (gi + 1) % N;
                m_xfers++;
                if (PERIOD != 0 && m_xfers == PERIOD) begin
                    m_serving   = 1'b0;
                    m_want_seed = 1'b1;
                    m_age       = -1;
                end
            end
        end else if (m_age >= 3 && !bus.prng_busy && bus.prng_out_valid) begin
            m_serving = 1'b1;
            m_age     = -1;
        end else begin
            m_age++;
        end
    endtask

    // One clock: drive inputs, sample and check at the falling edge, advance.
    task automatic tick(input logic sv, input logic [SEED_W-1:0] sd, input logic [N-1:0] rq,
                        input logic gap, input logic ovr, input logic ovr_busy,
                        input logic ovr_valid, output smp_t o);
        logic stub_busy;
        stub_busy = (stub_busy_left > 0);
        if (stub_busy) stub_busy_left--;
        bus.seed_valid     = sv;
        bus.seed           = sd;
        bus.req            = rq;
        bus.prng_busy      = ovr ? ovr_busy  : stub_busy;
        bus.prng_out_valid = ovr ? ovr_valid : (!stub_busy && stub_seeded && !gap);
        bus.prng_out_rnd   = RND'($urandom);
        @(negedge clk);
        o.grant      = bus.grant;
        o.seed_ready = bus.seed_ready;
        o.start      = bus.prng_start_reseed;
        o.reseeding  = bus.reseeding;
        o.out_ready  = bus.prng_out_ready;
        model_cycle();
        @(posedge clk);
        #1;
        if (o.start) begin
            stub_seeded    = 1'b1;
            stub_busy_left = busy_len;
        end
    endtask

    task automatic do_reseed(input logic [SEED_W-1:0] sd, input string tag);
        smp_t o;
        int pulses, pulse_at;
        bit up;
        pulses = 0; pulse_at = -1; up = 1'b0;
        tick(1'b1, sd, '0, 1'b0, 1'b0, 1'b0, 1'b0, o);
        chk({tag, ".accepted"}, 128'(o.seed_ready), 128'(1));
        for (int c = 1; c <= 40 && !up; c++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, o);
            if (o.start) begin pulses++; pulse_at = c; end
            if (!o.reseeding) up = 1'b1;
        end
        chk({tag, ".pulses"},    128'(pulses),        128'(1));
        chk({tag, ".pulse_at"},  128'(pulse_at),      128'(2));
        chk({tag, ".served"},    128'(up),            128'(1));
        chk({tag, ".prng_seed"}, 128'(bus.prng_seed), 128'(sd));
    endtask

    initial begin
        smp_t o;
        logic [N-1:0] g0, g1;
        logic [SEED_W-1:0] rs;
        int n2, other;
        bit need;

        cold_tab[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cold_tab[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cold_tab[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        cold_tab[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        cold_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        cold_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cold_tab[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        cold_tab[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            if (RR) arb_tab[i] = '{4'b1111, 4'(1 << (i % N)), 1'b0};
            else    arb_tab[i] = '{4'b1010, 4'b0010, 1'b0};
        end
        arb_tab[8] = '{RR ? 4'b1111 : 4'b1010, 4'b0000, 1'b1};

        model_reset();
        rst_n              = 1'b0;
        bus.seed_valid     = 1'b0;
        bus.seed           = '0;
        bus.req            = '0;
        bus.prng_busy      = 1'b0;
        bus.prng_out_valid = 1'b0;
        bus.prng_out_rnd   = '0;
        #12;
        chk("rst.grant",      128'(bus.grant),             128'(0));
        chk("rst.start",      128'(bus.prng_start_reseed), 128'(0));
        chk("rst.out_ready",  128'(bus.prng_out_ready),    128'(0));
        chk("rst.prng_seed",  128'(bus.prng_seed),         128'(0));
        chk("rst.seed_ready", 128'(bus.seed_ready),        128'(1));
        chk("rst.reseeding",  128'(bus.reseeding),         128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (cold_tab[i]) begin
            tick(cold_tab[i].sv, COLD_SEED, '0, 1'b0, 1'b1, cold_tab[i].bz, cold_tab[i].vl, o);
            chk($sformatf("cold[%0d].seed_ready", i), 128'(o.seed_ready), 128'(cold_tab[i].e_sr));
            chk($sformatf("cold[%0d].start", i),      128'(o.start),      128'(cold_tab[i].e_st));
            chk($sformatf("cold[%0d].reseeding", i),  128'(o.reseeding),  128'(cold_tab[i].e_rs));
        end
        chk("cold.prng_seed", 128'(bus.prng_seed), 128'(COLD_SEED));
        stub_busy_left = 0;

        foreach (arb_tab[i]) begin
            tick(1'b0, '0, arb_tab[i].rq, 1'b0, 1'b0, 1'b0, 1'b0, o);
            chk($sformatf("arb[%0d].grant", i),      128'(o.grant),      128'(arb_tab[i].e_g));
            chk($sformatf("arb[%0d].seed_ready", i), 128'(o.seed_ready), 128'(arb_tab[i].e_sr));
        end

        // Period reseed: a fresh seed, then exactly PERIOD grants to index 2.
        do_reseed(HIGH_SEED, "reseed1");
        n2 = 0; other = 0; need = 1'b0;
        for (int c = 0; c < 30 && !need; c++) begin
            tick(1'b0, '0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, o);
            if (o.grant == 4'b0100) n2++;
            else if (o.grant != '0) other++;
            if (o.seed_ready) need = 1'b1;
        end
        chk("period.grants_idx2", 128'(n2),    128'(PERIOD));
        chk("period.other",       128'(other), 128'(0));
        chk("period.need_seed",   128'(need),  128'(1));

        // Valid gap: three dead cycles must not move the turn.
        do_reseed(80'h0000_1111_2222_3333_4444, "reseed2");
        tick(1'b0, '0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, o);
        g0 = o.grant;
        chk("gap.before", 128'(g0), 128'(4'b0001));
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, '0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, o);
            chk("gap.grant",     128'(o.grant),     128'(0));
            chk("gap.out_ready", 128'(o.out_ready), 128'(0));
        end
        tick(1'b0, '0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, o);
        g1 = o.grant;
        chk("gap.after", 128'(g1), 128'(RR ? 4'b0010 : 4'b0001));

        // Reset asserted while waiting on the PRNG.
        need = 1'b0;
        for (int c = 0; c < 40 && !need; c++) begin
            tick(1'b0, '0, '1, 1'b0, 1'b0, 1'b0, 1'b0, o);
            need = o.seed_ready;
        end
        chk("mid.need_seed", 128'(need), 128'(1));
        tick(1'b1, 80'h5555_AAAA_5555_AAAA_5555, '0, 1'b0, 1'b0, 1'b0, 1'b0, o);
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, o);
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, o);
        tick(1'b0, '0, '1, 1'b0, 1'b0, 1'b0, 1'b0, o);
        chk("mid.in_wait", 128'({o.reseeding, o.seed_ready, o.start}), 128'(3'b100));
        rst_n = 1'b0;
        #1;
        chk("mid.grant",      128'(bus.grant),             128'(0));
        chk("mid.start",      128'(bus.prng_start_reseed), 128'(0));
        chk("mid.out_ready",  128'(bus.prng_out_ready),    128'(0));
        chk("mid.prng_seed",  128'(bus.prng_seed),         128'(0));
        chk("mid.seed_ready", 128'(bus.seed_ready),        128'(1));
        chk("mid.reseeding",  128'(bus.reseeding),         128'(1));
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b0, '0, '1, 1'b0, 1'b0, 1'b0, 1'b0, o);
        chk("mid.after_release", 128'(o.seed_ready), 128'(1));

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            busy_len = $urandom_range(1, 4);
            rs = {16'($urandom), $urandom, $urandom};
            tick($urandom_range(0, 3) == 0, rs, N'($urandom), $urandom_range(0, 9) == 0,
                 1'b0, 1'b0, 1'b0, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
